// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, WIDTH cycles per op.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              is_div, is_div_nxt;
  logic              neg_q, neg_q_nxt;     // negate product / quotient
  logic              neg_r, neg_r_nxt;     // negate remainder
  logic              div0, div0_nxt;
  logic [WIDTH-1:0]  acc_hi, acc_hi_nxt;   // product upper half / remainder
  logic [WIDTH-1:0]  acc_lo, acc_lo_nxt;   // multiplier->product lower / dividend->quotient
  logic [WIDTH-1:0]  opb, opb_nxt;         // multiplicand / divisor magnitude
  logic [WIDTH-1:0]  raw_a, raw_a_nxt;     // unmodified a, returned on divide by zero
  logic              busy_nxt, done_nxt;
  logic [WIDTH-1:0]  hi_nxt, lo_nxt;

  logic              accept, is_signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH-1:0]  mul_hi_n, mul_lo_n;
  logic [WIDTH:0]    div_sh;
  logic              div_ge;
  logic [WIDTH-1:0]  div_hi_n, div_lo_n;
  logic [2*WIDTH-1:0] mul_prod, mul_fix;
  logic [WIDTH-1:0]  q_fix, r_fix;
  logic [WIDTH-1:0]  step_hi, step_lo, fin_hi, fin_lo;

  // Operand conditioning at accept: magnitudes and sign flags for signed ops.
  always_comb begin
    accept       = start && !busy && (op >= OP_MULT) && (op <= OP_DIVU);
    is_signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg        = is_signed_op && a[WIDTH-1];
    b_neg        = is_signed_op && b[WIDTH-1];
    a_mag        = a_neg ? ('0 - a) : a;
    b_mag        = b_neg ? ('0 - b) : b;
  end

  // One iteration of shift-add multiply and restoring divide, plus final sign fix-up.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, opb};
    div_hi_n = div_ge ? WIDTH'(div_sh - {1'b0, opb}) : div_sh[WIDTH-1:0];
    div_lo_n = {acc_lo[WIDTH-2:0], div_ge};

    step_hi  = is_div ? div_hi_n : mul_hi_n;
    step_lo  = is_div ? div_lo_n : mul_lo_n;

    mul_prod = {mul_hi_n, mul_lo_n};
    mul_fix  = neg_q ? ('0 - mul_prod) : mul_prod;
    q_fix    = neg_q ? ('0 - div_lo_n) : div_lo_n;
    r_fix    = neg_r ? ('0 - div_hi_n) : div_hi_n;

    fin_hi   = mul_fix[2*WIDTH-1:WIDTH];
    fin_lo   = mul_fix[WIDTH-1:0];
    if (is_div) begin
      if (div0) begin
        fin_hi = raw_a;
        fin_lo = '1;
      end else begin
        fin_hi = r_fix;
        fin_lo = q_fix;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    is_div_nxt = is_div;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    div0_nxt   = div0;
    acc_hi_nxt = acc_hi;
    acc_lo_nxt = acc_lo;
    opb_nxt    = opb;
    raw_a_nxt  = raw_a;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    hi_nxt     = hi;
    lo_nxt     = lo;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = RUN;
          busy_nxt   = 1'b1;
          cnt_nxt    = '0;
          is_div_nxt = (op == OP_DIV) || (op == OP_DIVU);
          neg_q_nxt  = a_neg ^ b_neg;
          neg_r_nxt  = a_neg;
          div0_nxt   = (b == '0);
          acc_hi_nxt = '0;
          acc_lo_nxt = a_mag;
          opb_nxt    = b_mag;
          raw_a_nxt  = a;
        end else if (start && (op == OP_MTHI)) begin
          hi_nxt = a;
        end else if (start && (op == OP_MTLO)) begin
          lo_nxt = a;
        end
      end
      RUN: begin
        acc_hi_nxt = step_hi;
        acc_lo_nxt = step_lo;
        cnt_nxt    = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          hi_nxt    = fin_hi;
          lo_nxt    = fin_lo;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      raw_a  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      is_div <= is_div_nxt;
      neg_q  <= neg_q_nxt;
      neg_r  <= neg_r_nxt;
      div0   <= div0_nxt;
      acc_hi <= acc_hi_nxt;
      acc_lo <= acc_lo_nxt;
      opb    <= opb_nxt;
      raw_a  <= raw_a_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
    end
  end

endmodule
